// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_pkg;
  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] reg_word_t;

  function automatic logic is_zero_idx(input int unsigned idx, input bit zero_r0);
    return zero_r0 && (idx == 0);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set wins on collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       set_en_i,
  input  logic [AW-1:0]              set_addr_i,
  input  logic                       clr_en_i,
  input  logic [AW-1:0]              clr_addr_i,
  input  logic [NUM_RD-1:0][AW-1:0]  lk_addr_i,
  output logic [NUM_RD-1:0]          lk_busy_o,
  output logic [NUM_RD-1:0]          lk_busy_nxt_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (set_en_i && set_addr_i == AW'(i) && !is_zero_idx(32'(i), ZERO_R0 != 0))
        busy_d[i] = 1'b1;
      else if (clr_en_i && clr_addr_i == AW'(i))
        busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_lk
    assign lk_busy_o[p]     = busy_q[lk_addr_i[p]];
    assign lk_busy_nxt_o[p] = busy_d[lk_addr_i[p]];
  end
endmodule

// File: rtl/regfile_mport.sv
// Parametrised NUM_RD-read / 1-write register file with registered reads and busy scoreboard.
// REGFILE_BYPASS_EN forwards same-cycle writeback data (and next-state busy) to reads.
module regfile_mport
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD-1:0]             rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  output logic [NUM_RD-1:0]             rd_valid,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          busy_set_en,
  input  logic [AW-1:0]                 busy_set_addr
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [NUM_RD-1:0] sb_busy, sb_busy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en && !is_zero_idx(32'(wr_addr), ZERO_R0 != 0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_R0  (ZERO_R0)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_en_i      (busy_set_en),
    .set_addr_i    (busy_set_addr),
    .clr_en_i      (wr_en),
    .clr_addr_i    (wr_addr),
    .lk_addr_i     (rd_addr),
    .lk_busy_o     (sb_busy),
    .lk_busy_nxt_o (sb_busy_nxt)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic            zero, hit;
    logic [XLEN-1:0] data_d, data_q;
    logic            busy_d, busy_q, vld_q;

    assign zero   = is_zero_idx(32'(rd_addr[p]), ZERO_R0 != 0);
    assign hit    = BYPASS && wr_en && (wr_addr == rd_addr[p]) && !zero;
    assign data_d = zero ? '0 : (hit ? wr_data : regs_q[rd_addr[p]]);
    // On a forwarded hit the writeback clears busy unless a new producer issues this cycle.
    assign busy_d = !zero && (hit ? sb_busy_nxt[p] : sb_busy[p]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        busy_q <= 1'b0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_en[p];
        if (rd_en[p]) begin
          data_q <= data_d;
          busy_q <= busy_d;
        end
      end
    end

    assign rd_data[p]  = data_q;
    assign rd_busy[p]  = busy_q;
    assign rd_valid[p] = vld_q;
  end
endmodule

// File: tb/tb_regfile_mport.sv
// Self-checking bench: directed vector table plus random traffic against a reference model.
module tb_regfile_mport #(parameter int ZERO_R0 = 1);
  localparam int XLEN = 64, NUM_REGS = 64, NUM_RD = 4, AW = 6;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                        clk, rst_n;
  logic [NUM_RD-1:0]           rd_en;
  logic [NUM_RD-1:0][AW-1:0]   rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy, rd_valid;
  logic                        wr_en, busy_set_en;
  logic [AW-1:0]               wr_addr, busy_set_addr;
  logic [XLEN-1:0]             wr_data;

  regfile_mport #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .ZERO_R0(ZERO_R0)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_RD-1:0]           vld;
    logic [NUM_RD-1:0][XLEN-1:0] data;
    logic [NUM_RD-1:0]           busy;
  } exp_t;

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            bs;
    logic [AW-1:0]   ba;
    logic            re;
    logic [AW-1:0]   ra;
    logic            chk;
    logic [XLEN-1:0] exp_d;
    logic            exp_b;
  } vec_t;

  exp_t                        sb_q[$];
  logic [XLEN-1:0]             m_regs [NUM_REGS];
  logic [NUM_REGS-1:0]         m_busy;
  logic [NUM_RD-1:0][XLEN-1:0] m_rd_data;
  logic [NUM_RD-1:0]           m_rd_busy;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit mz(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_busy    = '0;
    m_rd_data = '0;
    m_rd_busy = '0;
  endtask

  task automatic set_in(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                        input logic bs, input logic [AW-1:0] ba, input logic re, input logic [AW-1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; busy_set_en = bs; busy_set_addr = ba;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_en[p]   = re;
      rd_addr[p] = ra;
    end
  endtask

  // Predict this edge's results, push them, advance the model, then pop and compare.
  task automatic cycle();
    exp_t                e;
    logic                hit, nbit;
    logic [AW-1:0]       a;
    logic [NUM_REGS-1:0] nb;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        a    = rd_addr[p];
        hit  = BYP && wr_en && (wr_addr == a) && !mz(a);
        nbit = (busy_set_en && busy_set_addr == a && !mz(a)) ? 1'b1 :
               (wr_en && wr_addr == a) ? 1'b0 : m_busy[a];
        m_rd_data[p] = mz(a) ? '0 : (hit ? wr_data : m_regs[a]);
        m_rd_busy[p] = mz(a) ? 1'b0 : (hit ? nbit : m_busy[a]);
      end
    end
    e.vld = rd_en; e.data = m_rd_data; e.busy = m_rd_busy;
    sb_q.push_back(e);
    if (wr_en && !mz(wr_addr)) m_regs[wr_addr] = wr_data;
    nb = m_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (busy_set_en && busy_set_addr == AW'(i) && !mz(AW'(i))) nb[i] = 1'b1;
      else if (wr_en && wr_addr == AW'(i))                        nb[i] = 1'b0;
    end
    m_busy = nb;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    for (int p = 0; p < NUM_RD; p++) begin
      chk($sformatf("rd_valid[%0d]", p), XLEN'(rd_valid[p]), XLEN'(e.vld[p]));
      chk($sformatf("rd_data[%0d]", p),  rd_data[p],         e.data[p]);
      chk($sformatf("rd_busy[%0d]", p),  XLEN'(rd_busy[p]),  XLEN'(e.busy[p]));
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                              input logic bs, input logic [AW-1:0] ba, input logic re,
                              input logic [AW-1:0] ra, input logic c, input logic [XLEN-1:0] ed,
                              input logic eb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.bs = bs; v.ba = ba; v.re = re; v.ra = ra;
    v.chk = c; v.exp_d = ed; v.exp_b = eb;
    return v;
  endfunction

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NUM_REGS-1));
  endfunction

  vec_t tbl [16];

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, '0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      chk($sformatf("init_valid[%0d]", p), XLEN'(rd_valid[p]), '0);
      chk($sformatf("init_data[%0d]", p),  rd_data[p],         '0);
    end
    rst_n = 1'b1;

    // Reset mid-operation: preload, read, then async reset between edges.
    set_in(1, 3, 64'h55, 1, 4, 0, 0);  cycle();
    set_in(0, 0, '0, 0, 0, 1, 3);       cycle();
    set_in(1, 3, 64'h99, 1, 5, 0, 0);
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      chk($sformatf("rst_data[%0d]", p),  rd_data[p],         '0);
      chk($sformatf("rst_valid[%0d]", p), XLEN'(rd_valid[p]), '0);
      chk($sformatf("rst_busy[%0d]", p),  XLEN'(rd_busy[p]),  '0);
    end
    set_in(0, 0, '0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    model_reset();
    set_in(0, 0, '0, 0, 0, 1, 3);  cycle();
    chk("post_rst_x3", rd_data[0], '0);
    set_in(0, 0, '0, 0, 0, 1, 4);  cycle();
    chk("post_rst_busy_x4", XLEN'(rd_busy[0]), '0);

    // Directed table: {we, wa, wd, bs, ba, re, ra, chk, exp_data, exp_busy}
    tbl[0]  = mk(1, 5, 64'hDEADBEEF, 0, 0, 0, 0, 0, '0, 0);
    tbl[1]  = mk(0, 0, '0,           0, 0, 1, 5, 1, 64'hDEADBEEF, 0);
    tbl[2]  = mk(1, 0, 64'hFFFFFFFF, 1, 0, 0, 0, 0, '0, 0);
    tbl[3]  = mk(0, 0, '0,           0, 0, 1, 0, 1, (ZERO_R0 != 0) ? 64'h0 : 64'hFFFFFFFF, ZERO_R0 == 0);
    tbl[4]  = mk(1, 7, 64'h1,        0, 0, 0, 0, 0, '0, 0);
    tbl[5]  = mk(1, 7, 64'h12345678, 0, 0, 1, 7, 1, BYP ? 64'h12345678 : 64'h1, 0);
    tbl[6]  = mk(0, 0, '0,           0, 0, 1, 7, 1, 64'h12345678, 0);
    tbl[7]  = mk(0, 0, '0,           1, 9, 0, 0, 0, '0, 0);
    tbl[8]  = mk(0, 0, '0,           0, 0, 1, 9, 1, 64'h0, 1);
    tbl[9]  = mk(1, 9, 64'hAA,       0, 0, 0, 0, 0, '0, 0);
    tbl[10] = mk(0, 0, '0,           0, 0, 1, 9, 1, 64'hAA, 0);
    tbl[11] = mk(1, 9, 64'hBB,       1, 9, 0, 0, 0, '0, 0);
    tbl[12] = mk(0, 0, '0,           0, 0, 1, 9, 1, 64'hBB, 1);
    tbl[13] = mk(1, 9, 64'hCC,       1, 9, 1, 9, 1, BYP ? 64'hCC : 64'hBB, 1);
    tbl[14] = mk(1, 9, 64'hDD,       0, 0, 1, 9, 1, BYP ? 64'hDD : 64'hCC, !BYP);
    tbl[15] = mk(0, 0, '0,           0, 0, 0, 0, 1, BYP ? 64'hDD : 64'hCC, !BYP);
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].bs, tbl[i].ba, tbl[i].re, tbl[i].ra);
      cycle();
      if (tbl[i].chk) begin
        for (int p = 0; p < NUM_RD; p++) begin
          chk($sformatf("vec%0d_data[%0d]", i, p), rd_data[p],        tbl[i].exp_d);
          chk($sformatf("vec%0d_busy[%0d]", i, p), XLEN'(rd_busy[p]), XLEN'(tbl[i].exp_b));
        end
      end
    end
    set_in(0, 0, '0, 0, 0, 1, 9);  cycle();

    // Random traffic concentrated on a few indices to provoke collisions.
    for (int n = 0; n < 10000; n++) begin
      wr_en         = 1'($urandom_range(0, 1));
      wr_addr       = raddr();
      wr_data       = {$urandom, $urandom};
      busy_set_en   = 1'($urandom_range(0, 1));
      busy_set_addr = raddr();
      for (int p = 0; p < NUM_RD; p++) begin
        rd_en[p]   = 1'($urandom_range(0, 1));
        rd_addr[p] = raddr();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
